// File: rtl/io_resp_pkg.sv
// Shared register map, bit positions and bus FSM encoding for the
// HPS IO-bus camera responder.
package io_resp_pkg;

    localparam logic [3:0] REG_CTRL      = 4'h0;
    localparam logic [3:0] REG_STATUS    = 4'h2;
    localparam logic [3:0] REG_LEVEL     = 4'h4;
    localparam logic [3:0] REG_THRESH    = 4'h6;
    localparam logic [3:0] REG_DATA      = 4'h8;
    localparam logic [3:0] REG_FRAME_CNT = 4'hA;

    localparam int CTRL_ENABLE     = 0;
    localparam int CTRL_IRQ_EN     = 1;
    localparam int CTRL_FIFO_CLEAR = 2;

    localparam int ST_EMPTY      = 0;
    localparam int ST_FULL       = 1;
    localparam int ST_OVERFLOW   = 2;
    localparam int ST_IRQ        = 3;
    localparam int ST_FRAME_SEEN = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK,
        S_RECOVER
    } bus_state_e;

endpackage

// File: rtl/resp_sync_fifo.sv
// Single-clock pixel FIFO with show-ahead output: dout always presents the
// oldest entry, so a pop only has to advance the read pointer.
module resp_sync_fifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pop;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign dout    = mem_q[rd_ptr_q];

    // Clear dominates both ports; a pop on empty is ignored so a same-cycle
    // push into an empty FIFO is kept.
    assign do_push = push & ~full & ~clear;
    assign do_pop  = pop & ~empty & ~clear;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (do_push && !do_pop)      level_d = level_q + LW'(1);
            else if (!do_push && do_pop) level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/io_bus_cam_responder.sv
// HPS IO-bridge responder buffering a camera pixel stream with level/overflow irq.
// Optional FRAME_CNT register and STATUS frame-seen bit: define IO_RESP_FRAME_COUNT_EN.
module io_bus_cam_responder
    import io_resp_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR   = 16'h0100,
    parameter int          FIFO_DEPTH  = 64,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] io_address,
    input  logic        io_bus_enable,
    input  logic [1:0]  io_byte_enable,
    input  logic        io_rw,
    input  logic [15:0] io_write_data,
    output logic [15:0] io_read_data,
    output logic        io_acknowledge,
    output logic        io_irq,
    input  logic        pix_valid,
    input  logic [15:0] pix_data,
    output logic        pix_ready,
    input  logic        frame_start,
    output logic        cam_enable
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    function automatic logic [15:0] merge_lanes(input logic [15:0] old_v,
                                                input logic [15:0] new_v,
                                                input logic [1:0]  be);
        merge_lanes[7:0]  = be[0] ? new_v[7:0]  : old_v[7:0];
        merge_lanes[15:8] = be[1] ? new_v[15:8] : old_v[15:8];
    endfunction

    bus_state_e  state_q, state_d;
    logic [2:0]  wait_cnt_q, wait_cnt_d;
    logic [3:1]  addr_q, addr_d;
    logic        rw_q, rw_d;
    logic [15:0] wdata_q, wdata_d;
    logic [1:0]  be_q, be_d;
    logic        enable_q, enable_d;
    logic        irq_en_q, irq_en_d;
    logic [15:0] thresh_q, thresh_d;
    logic        overflow_q, overflow_d;
    logic        irq_q, irq_d;

    logic          hit, ack, wr_commit, rd_commit, sw_clear;
    logic          fifo_push, fifo_pop, fifo_clear, fifo_full, fifo_empty;
    logic [15:0]   fifo_dout;
    logic [LW-1:0] fifo_level;
    logic [15:0]   level_ext, frame_cnt, status_word, rdata;
    logic [3:0]    reg_sel;
    logic          frame_seen;
    logic          unused_addr_lsb;

    assign unused_addr_lsb = io_address[0];

    assign hit       = (io_address[15:4] == BASE_ADDR[15:4]);
    assign ack       = (state_q == S_ACK);
    assign wr_commit = ack & ~rw_q;
    assign rd_commit = ack & rw_q;
    assign reg_sel   = {addr_q, 1'b0};
    assign level_ext = {{(16 - LW){1'b0}}, fifo_level};

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        addr_d     = addr_q;
        rw_d       = rw_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        unique case (state_q)
            S_IDLE: begin
                if (io_bus_enable && hit) begin
                    addr_d     = io_address[3:1];
                    rw_d       = io_rw;
                    wdata_d    = io_write_data;
                    be_d       = io_byte_enable;
                    wait_cnt_d = '0;
                    state_d    = (WAIT_STATES == 0) ? S_ACK : S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == 3'(WAIT_STATES - 1)) state_d = S_ACK;
                else                                   wait_cnt_d = wait_cnt_q + 3'd1;
            end
            S_ACK:     state_d = S_RECOVER;
            // One dead cycle lets the bridge drop bus_enable before we look again.
            S_RECOVER: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    assign sw_clear   = wr_commit && (reg_sel == REG_CTRL) && be_q[0] && wdata_q[CTRL_FIFO_CLEAR];
    assign fifo_clear = sw_clear | (frame_start & enable_q);
    assign pix_ready  = enable_q & ~fifo_full;
    assign fifo_push  = pix_valid & pix_ready;
    assign fifo_pop   = rd_commit && (reg_sel == REG_DATA);
    assign cam_enable = enable_q;
    assign io_irq     = irq_q;

    always_comb begin
        enable_d   = enable_q;
        irq_en_d   = irq_en_q;
        thresh_d   = thresh_q;
        overflow_d = overflow_q;
        if (wr_commit) begin
            case (reg_sel)
                REG_CTRL: begin
                    if (be_q[0]) begin
                        enable_d = wdata_q[CTRL_ENABLE];
                        irq_en_d = wdata_q[CTRL_IRQ_EN];
                    end
                end
                REG_STATUS: if (be_q[0] && wdata_q[ST_OVERFLOW]) overflow_d = 1'b0;
                REG_THRESH: thresh_d = merge_lanes(thresh_q, wdata_q, be_q);
                default: ;
            endcase
        end
        // A fresh overflow event wins over a same-cycle W1C.
        if (pix_valid && enable_q && fifo_full) overflow_d = 1'b1;
        irq_d = irq_en_q & (((thresh_q != '0) && (level_ext >= thresh_q)) | overflow_q);
    end

`ifdef IO_RESP_FRAME_COUNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        frame_seen_q, frame_seen_d;

    always_comb begin
        frame_cnt_d  = frame_cnt_q;
        frame_seen_d = frame_seen_q;
        if (rd_commit && (reg_sel == REG_STATUS)) frame_seen_d = 1'b0;
        if (frame_start && enable_q) begin
            frame_cnt_d  = frame_cnt_q + 16'd1;
            frame_seen_d = 1'b1;
        end
        if (sw_clear) frame_cnt_d = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_q  <= '0;
            frame_seen_q <= 1'b0;
        end else begin
            frame_cnt_q  <= frame_cnt_d;
            frame_seen_q <= frame_seen_d;
        end
    end

    assign frame_cnt  = frame_cnt_q;
    assign frame_seen = frame_seen_q;
`else
    assign frame_cnt  = '0;
    assign frame_seen = 1'b0;
`endif

    assign status_word = {11'b0, frame_seen, irq_q, overflow_q, fifo_full, fifo_empty};

    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_CTRL:      rdata = {14'b0, irq_en_q, enable_q};
            REG_STATUS:    rdata = status_word;
            REG_LEVEL:     rdata = level_ext;
            REG_THRESH:    rdata = thresh_q;
            REG_DATA:      rdata = fifo_empty ? 16'h0000 : fifo_dout;
            REG_FRAME_CNT: rdata = frame_cnt;
            default:       rdata = '0;
        endcase
        io_acknowledge = ack;
        io_read_data   = ack ? rdata : 16'h0000;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
            addr_q     <= '0;
            rw_q       <= 1'b0;
            wdata_q    <= '0;
            be_q       <= '0;
            enable_q   <= 1'b0;
            irq_en_q   <= 1'b0;
            thresh_q   <= '0;
            overflow_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            addr_q     <= addr_d;
            rw_q       <= rw_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            enable_q   <= enable_d;
            irq_en_q   <= irq_en_d;
            thresh_q   <= thresh_d;
            overflow_q <= overflow_d;
            irq_q      <= irq_d;
        end
    end

    resp_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .clear   (fifo_clear),
        .din     (pix_data),
        .dout    (fifo_dout),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_io_bus_cam_responder.sv
// Scoreboard bench for io_bus_cam_responder: expected read words are queued
// before each access and popped when the acknowledge arrives.
module tb_io_bus_cam_responder;

    localparam int          FIFO_DEPTH = 64;
    localparam logic [15:0] A_CTRL     = 16'h0100;
    localparam logic [15:0] A_STATUS   = 16'h0102;
    localparam logic [15:0] A_LEVEL    = 16'h0104;
    localparam logic [15:0] A_THRESH   = 16'h0106;
    localparam logic [15:0] A_DATA     = 16'h0108;
    localparam logic [15:0] A_FCNT     = 16'h010A;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] io_address;
    logic        io_bus_enable;
    logic [1:0]  io_byte_enable;
    logic        io_rw;
    logic [15:0] io_write_data;
    logic [15:0] io_read_data;
    logic        io_acknowledge;
    logic        io_irq;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic        pix_ready;
    logic        frame_start;
    logic        cam_enable;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    io_bus_cam_responder #(
        .BASE_ADDR   (16'h0100),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .WAIT_STATES (1)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .io_address     (io_address),
        .io_bus_enable  (io_bus_enable),
        .io_byte_enable (io_byte_enable),
        .io_rw          (io_rw),
        .io_write_data  (io_write_data),
        .io_read_data   (io_read_data),
        .io_acknowledge (io_acknowledge),
        .io_irq         (io_irq),
        .pix_valid      (pix_valid),
        .pix_data       (pix_data),
        .pix_ready      (pix_ready),
        .frame_start    (frame_start),
        .cam_enable     (cam_enable)
    );

    // One bridge transfer; waits up to 20 cycles for acknowledge.
    task automatic bus_xfer(input logic [15:0] addr, input logic rw, input logic [15:0] wd,
                            input logic [1:0] be, input logic expect_ack,
                            output logic [15:0] rd, output int lat, output logic acked);
        @(negedge clk);
        io_address = addr; io_rw = rw; io_write_data = wd; io_byte_enable = be;
        io_bus_enable = 1'b1;
        rd = '0; lat = 0; acked = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            lat++;
            if (io_acknowledge) begin
                acked = 1'b1;
                rd = io_read_data;
                break;
            end
        end
        io_bus_enable = 1'b0;
        if (expect_ack && !acked) begin
            total++; bad++;
            $display("FAIL ack_timeout addr=%h got no acknowledge, required one", addr);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    // Read whose acknowledge cycle coincides with a pixel push.
    task automatic bus_read_push(input logic [15:0] addr, input logic [15:0] pix,
                                 output logic [15:0] rd);
        logic acked;
        @(negedge clk);
        io_address = addr; io_rw = 1'b1; io_byte_enable = 2'b11; io_bus_enable = 1'b1;
        rd = '0; acked = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (io_acknowledge) begin
                acked = 1'b1;
                rd = io_read_data;
                pix_valid = 1'b1;
                pix_data = pix;
                break;
            end
        end
        io_bus_enable = 1'b0;
        if (!acked) begin
            total++; bad++;
            $display("FAIL ack_timeout addr=%h got no acknowledge, required one", addr);
        end
        @(posedge clk); #1;
        pix_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic push_pix(input logic [15:0] d);
        @(negedge clk);
        pix_valid = 1'b1; pix_data = d;
        @(posedge clk); #1;
        pix_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] rd, e; int lat; logic acked;
        reset_n = 1'b0;
        io_address = '0; io_bus_enable = 1'b0; io_byte_enable = '0; io_rw = 1'b0;
        io_write_data = '0; pix_valid = 1'b0; pix_data = '0; frame_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({io_acknowledge, io_read_data, io_irq, pix_ready, cam_enable} !== 20'h0) begin
            bad++;
            $display("FAIL reset_outputs got=%h required=0",
                     {io_acknowledge, io_read_data, io_irq, pix_ready, cam_enable});
        end
        @(negedge clk); reset_n = 1'b1;
        // Start a STATUS read and pull reset while it sits in WAIT.
        @(negedge clk);
        io_address = A_STATUS; io_rw = 1'b1; io_byte_enable = 2'b11; io_bus_enable = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        total++;
        if ({io_acknowledge, io_read_data, io_irq, pix_ready, cam_enable} !== 20'h0) begin
            bad++;
            $display("FAIL reset_mid_wait got=%h required=0",
                     {io_acknowledge, io_read_data, io_irq, pix_ready, cam_enable});
        end
        @(posedge clk); #1;
        total++;
        if (io_acknowledge !== 1'b0) begin
            bad++; $display("FAIL reset_no_ack ack=%b required=0", io_acknowledge);
        end
        @(negedge clk); reset_n = 1'b1; io_bus_enable = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        exp_q.push_back(16'h0001);
        bus_xfer(A_STATUS, 1'b1, '0, 2'b11, 1'b1, rd, lat, acked);
        e = exp_q.pop_front(); total++;
        if (rd !== e) begin bad++; $display("FAIL status_after_reset got=%h required=%h", rd, e); end
    endtask

    task automatic test_registers();
        logic [15:0] rd, e; int lat; logic acked;
        bus_xfer(A_THRESH, 1'b0, 16'h0010, 2'b01, 1'b1, rd, lat, acked);
        total++;
        if (lat !== 2) begin bad++; $display("FAIL ack_latency got=%0d required=2", lat); end
        exp_q.push_back(16'h0010);
        bus_xfer(A_THRESH, 1'b1, '0, 2'b11, 1'b1, rd, lat, acked);
        e = exp_q.pop_front(); total++;
        if (rd !== e) begin bad++; $display("FAIL thresh_low_lane got=%h required=%h", rd, e); end
        bus_xfer(A_THRESH, 1'b0, 16'hAB00, 2'b10, 1'b1, rd, lat, acked);
        exp_q.push_back(16'hAB10);
        bus_xfer(A_THRESH, 1'b1, '0, 2'b11, 1'b1, rd, lat, acked);
        e = exp_q.pop_front(); total++;
        if (rd !== e) begin bad++; $display("FAIL thresh_high_lane got=%h required=%h", rd, e); end
        bus_xfer(A_LEVEL, 1'b0, 16'hFFFF, 2'b11, 1'b1, rd, lat, acked);
        exp_q.push_back(16'h0000);
        bus_xfer(A_LEVEL, 1'b1, '0, 2'b11, 1'b1, rd, lat, acked);
        e = exp_q.pop_front(); total++;
        if (rd !== e) begin bad++; $display("FAIL level_ro_write got=%h required=%h", rd, e); end
        bus_xfer(16'h010C, 1'b0, 16'h1234, 2'b11, 1'b1, rd, lat, acked);
        exp_q.push_back(16'h0000);
        bus_xfer(16'h010C, 1'b1, '0, 2'b11, 1'b1, rd, lat, acked);
        e = exp_q.pop_front(); total++;
        if (rd !== e) begin bad++; $display("FAIL reserved_reads_zero got=%h required=%h", rd, e); end
    endtask

    task automatic test_stream_irq();
        logic [15:0] rd, e; int lat; logic acked;
        logic [15:0] pix [4];
        pix[0] = 16'h1111; pix[1] = 16'h2222; pix[2] = 16'h3333; pix[3] = 16'h4444;
        bus_xfer(A_THRESH, 1'b0, 16'h0004, 2'b11, 1'b1, rd, lat, acked);
        bus_xfer(A_CTRL, 1'b0, 16'h0003, 2'b11, 1'b1, rd, lat, acked);
        total++;
        if (cam_enable !== 1'b1) begin bad++; $display("FAIL cam_enable got=%b required=1", cam_enable); end
        for (int i = 0; i < 3; i++) push_pix(pix[i]);
        push_pix(pix[3]);
        total++;
        if (io_irq !== 1'b0) begin bad++; $display("FAIL irq_not_early got=%b required=0", io_irq); end
        @(posedge clk); #1;
        total++;
        if (io_irq !== 1'b1) begin bad++; $display("FAIL irq_rise got=%b required=1", io_irq); end
        exp_q.push_back(16'h0004);
        bus_xfer(A_LEVEL, 1'b1, '0, 2'b11, 1'b1, rd, lat, acked);
        e = exp_q.pop_front(); total++;
        if (rd !== e) begin bad++; $display("FAIL level_four got=%h required=%h", rd, e); end
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(pix[i]);
            bus_xfer(A_DATA, 1'b1, '0, 2'b11, 1'b1, rd, lat, acked);
            e = exp_q.pop_front(); total++;
            if (rd !== e) begin bad++; $display("FAIL data_order[%0d] got=%h required=%h", i, rd, e); end
        end
        exp_q.push_back(16'h0000);
        bus_xfer(A_LEVEL, 1'b1, '0, 2'b11, 1'b1, rd, lat, acked);
        e = exp_q.pop_front(); total++;
        if (rd !== e) begin bad++; $display("FAIL level_drained got=%h required=%h", rd, e); end
        total++;
        if (io_irq !== 1'b0) begin bad++; $display("FAIL irq_fall got=%b required=0", io_irq); end
    endtask

    task automatic test_overflow();
        logic [15:0] rd, e; int lat; logic acked;
        for (int i = 0; i < FIFO_DEPTH + 3; i++) begin
            @(negedge clk);
            pix_valid = 1'b1; pix_data = 16'hA000 + 16'(i);
            if (i == FIFO_DEPTH - 1) begin
                total++;
                if (pix_ready !== 1'b1) begin bad++; $display("FAIL ready_before_full got=%b required=1", pix_ready); end
            end
            if (i == FIFO_DEPTH) begin
                total++;
                if (pix_ready !== 1'b0) begin bad++; $display("FAIL ready_at_full got=%b required=0", pix_ready); end
            end
        end
        @(negedge clk); pix_valid = 1'b0;
        exp_q.push_back(16'h000E);
        bus_xfer(A_STATUS, 1'b1, '0, 2'b11, 1'b1, rd, lat, acked);
        e = exp_q.pop_front(); total++;
        if (rd !== e) begin bad++; $display("FAIL status_overflow got=%h required=%h", rd, e); end
        exp_q.push_back(16'(FIFO_DEPTH));
        bus_xfer(A_LEVEL, 1'b1, '0, 2'b11, 1'b1, rd, lat, acked);
        e = exp_q.pop_front(); total++;
        if (rd !== e) begin bad++; $display("FAIL level_full got=%h required=%h", rd, e); end
        bus_xfer(A_STATUS, 1'b0, 16'h0004, 2'b01, 1'b1, rd, lat, acked);
        exp_q.push_back(16'h000A);
        bus_xfer(A_STATUS, 1'b1, '0, 2'b11, 1'b1, rd, lat, acked);
        e = exp_q.pop_front(); total++;
        if (rd !== e) begin bad++; $display("FAIL status_w1c got=%h required=%h", rd, e); end
        bus_xfer(A_THRESH, 1'b0, 16'h0000, 2'b11, 1'b1, rd, lat, acked);
        exp_q.push_back(16'h0002);
        bus_xfer(A_STATUS, 1'b1, '0, 2'b11, 1'b1, rd, lat, acked);
        e = exp_q.pop_front(); total++;
        if (rd !== e) begin bad++; $display("FAIL status_thresh_off got=%h required=%h", rd, e); end
        exp_q.push_back(16'hA000);
        bus_xfer(A_DATA, 1'b1, '0, 2'b11, 1'b1, rd, lat, acked);
        e = exp_q.pop_front(); total++;
        if (rd !== e) begin bad++; $display("FAIL data_after_overflow got=%h required=%h", rd, e); end
        exp_q.push_back(16'(FIFO_DEPTH - 1));
        bus_xfer(A_LEVEL, 1'b1, '0, 2'b11, 1'b1, rd, lat, acked);
        e = exp_q.pop_front(); total++;
        if (rd !== e) begin bad++; $display("FAIL level_after_pop got=%h required=%h", rd, e); end
    endtask

    task automatic test_edge_cases();
        logic [15:0] rd, e; int lat; logic acked;
        bus_xfer(16'h0200, 1'b1, '0, 2'b11, 1'b0, rd, lat, acked);
        total++;
        if (acked !== 1'b0) begin bad++; $display("FAIL miss_no_ack got=%b required=0", acked); end
        bus_xfer(A_CTRL, 1'b0, 16'h0005, 2'b01, 1'b1, rd, lat, acked);
        exp_q.push_back(16'h0000);
        bus_xfer(A_LEVEL, 1'b1, '0, 2'b11, 1'b1, rd, lat, acked);
        e = exp_q.pop_front(); total++;
        if (rd !== e) begin bad++; $display("FAIL level_after_clear got=%h required=%h", rd, e); end
        exp_q.push_back(16'h0001);
        bus_xfer(A_CTRL, 1'b1, '0, 2'b11, 1'b1, rd, lat, acked);
        e = exp_q.pop_front(); total++;
        if (rd !== e) begin bad++; $display("FAIL ctrl_clear_reads_zero got=%h required=%h", rd, e); end
        exp_q.push_back(16'h0000);
        bus_xfer(A_DATA, 1'b1, '0, 2'b11, 1'b1, rd, lat, acked);
        e = exp_q.pop_front(); total++;
        if (rd !== e) begin bad++; $display("FAIL data_empty got=%h required=%h", rd, e); end
        exp_q.push_back(16'h0000);
        bus_read_push(A_DATA, 16'hC0DE, rd);
        e = exp_q.pop_front(); total++;
        if (rd !== e) begin bad++; $display("FAIL empty_pop_push_read got=%h required=%h", rd, e); end
        exp_q.push_back(16'hC0DE);
        bus_xfer(A_DATA, 1'b1, '0, 2'b11, 1'b1, rd, lat, acked);
        e = exp_q.pop_front(); total++;
        if (rd !== e) begin bad++; $display("FAIL empty_pop_push_kept got=%h required=%h", rd, e); end
        for (int i = 0; i < 5; i++) push_pix(16'hB000 + 16'(i));
        exp_q.push_back(16'hB000);
        bus_read_push(A_DATA, 16'hB005, rd);
        e = exp_q.pop_front(); total++;
        if (rd !== e) begin bad++; $display("FAIL pop_push_data got=%h required=%h", rd, e); end
        exp_q.push_back(16'h0005);
        bus_xfer(A_LEVEL, 1'b1, '0, 2'b11, 1'b1, rd, lat, acked);
        e = exp_q.pop_front(); total++;
        if (rd !== e) begin bad++; $display("FAIL pop_push_level got=%h required=%h", rd, e); end
        exp_q.push_back(16'hB001);
        bus_xfer(A_DATA, 1'b1, '0, 2'b11, 1'b1, rd, lat, acked);
        e = exp_q.pop_front(); total++;
        if (rd !== e) begin bad++; $display("FAIL pop_push_next got=%h required=%h", rd, e); end
        @(negedge clk); frame_start = 1'b1;
        @(negedge clk); frame_start = 1'b0;
        exp_q.push_back(16'h0000);
        bus_xfer(A_LEVEL, 1'b1, '0, 2'b11, 1'b1, rd, lat, acked);
        e = exp_q.pop_front(); total++;
        if (rd !== e) begin bad++; $display("FAIL frame_start_clear got=%h required=%h", rd, e); end
`ifdef IO_RESP_FRAME_COUNT_EN
        exp_q.push_back(16'h0001);
        exp_q.push_back(16'h0011);
`else
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0001);
`endif
        bus_xfer(A_FCNT, 1'b1, '0, 2'b11, 1'b1, rd, lat, acked);
        e = exp_q.pop_front(); total++;
        if (rd !== e) begin bad++; $display("FAIL frame_cnt got=%h required=%h", rd, e); end
        bus_xfer(A_STATUS, 1'b1, '0, 2'b11, 1'b1, rd, lat, acked);
        e = exp_q.pop_front(); total++;
        if (rd !== e) begin bad++; $display("FAIL status_frame_seen got=%h required=%h", rd, e); end
        exp_q.push_back(16'h0001);
        bus_xfer(A_STATUS, 1'b1, '0, 2'b11, 1'b1, rd, lat, acked);
        e = exp_q.pop_front(); total++;
        if (rd !== e) begin bad++; $display("FAIL status_seen_cleared got=%h required=%h", rd, e); end
    endtask

    initial begin
        test_reset();
        test_registers();
        test_stream_irq();
        test_overflow();
        test_edge_cases();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
